gemm_tile_loader: RTL
=====================

// Module: gemm_tile_loader
// PURPOSE
//  Upstream read master for the banked scratchpad's GEMM interface port. On start, walks a
//  tile of num_rows rows, each row_bytes wide, from base_addr with byte stride row_stride.
//  Issues one unaligned 16-byte-lane read per row; memory returns data 1 cycle later.
//  Rows stream out on a valid/ready link into the systolic-array input skew stage.
// PARAMETERS
//  LANES     16  bytes per row transaction; must equal the scratchpad NUM_RAMS
//  D_WID     8   bits per lane
//  ROW_W     5   width of num_rows / row_bytes counters (max 16 rows)
// PORTS
//  clk            in   1            clock
//  rst            in   1            asynchronous, active-high reset
//  start          in   1            1-cycle pulse; captures the configuration below
//  base_addr      in   32           byte address of row 0
//  row_stride     in   32           byte distance between consecutive rows
//  num_rows       in   ROW_W        rows in tile, 0..16
//  row_bytes      in   ROW_W        valid bytes per row, 0..16; values >16 clamp to 16
//  busy           out  1            high from the cycle after start until done
//  done           out  1            1-cycle pulse after the last row handshakes out
//  mem_en         out  1            to interface_en
//  mem_rdwr       out  1            to interface_rdwr; tied 0 (read only)
//  mem_control    out  5            to interface_control; byte count = clamped row_bytes
//  mem_addr       out  32           to interface_addr
//  mem_rd_data    in   LANES*D_WID  from interface_rd_data; valid 1 cycle after mem_en
//  out_valid      out  1            row available
//  out_ready      in   1            consumer accepts row when valid&ready
//  out_data       out  LANES*D_WID  row bytes, lane 0 = lowest address
//  out_last       out  1            qualifies out_valid for the final row
// BEHAVIOUR
//  - Reset (async, any state): IDLE; busy=0, done=0, mem_en=0, mem_rdwr=0, mem_control=0,
//    mem_addr=0, out_valid=0, out_last=0, out_data=0; FIFO and counters cleared.
//  - FSM: IDLE -start-> ISSUE; ISSUE -last row issued-> DRAIN; DRAIN -FIFO empty and no
//    read in flight-> DONE; DONE -> IDLE (done=1 for exactly that cycle).
//  - start while busy: ignored. start with num_rows==0 or row_bytes==0: IDLE->DONE
//    directly; zero memory transactions; done pulses 2 cycles after start.
//  - Issue rule: mem_en=1 in a cycle only if fifo_count + inflight < 2, counted after
//    this cycle's pop (credit scheme). The 2-entry FIFO absorbs the 1-cycle latency;
//    data is never dropped under out_ready backpressure.
//  - Row r address = base_addr + r*row_stride: a running 32-bit adder, wraps mod 2^32.
//  - inflight register = mem_en delayed 1 cycle; when set, push mem_rd_data into FIFO.
//  - Full throughput: with out_ready held high, one row per cycle after a 2-cycle fill.
//    First out_valid is 2 cycles after start.
//  - Lanes >= row_bytes arrive zeroed from memory; the loader passes them through unchanged.
//  - out_last is set on the FIFO entry of row num_rows-1; it is stored per entry.
//  - Simultaneous push and pop with a full FIFO is impossible by the credit rule;
//    assertion required.
// CONFIGURATION
//  LOADER_PERF_CNT_EN defined: adds port stall_cycles out 32. It counts cycles with
//    busy & out_valid & !out_ready, clears on accepted start, saturates at 2^32-1, and
//    resets to 0.
//  Undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  gemm_pkg: LANES, D_WID, typedef row_t = logic [LANES-1:0][D_WID-1:0], and
//    typedef enum {IDLE, ISSUE, DRAIN, DONE} loader_state_e.
//  Sub-module: loader_row_fifo, a 2-entry {row_t, last} FIFO with count; push/pop/full/empty.
// TESTING
//  1 base=0x40, stride=16, rows=4, bytes=16, ready=1 -> 4 reads at 0x40..0x70 on
//    consecutive cycles; rows out back-to-back; last on row 3; done 1 cycle after.
//  2 base=0x13, stride=20, rows=3, bytes=5 -> mem_control=5; addrs 0x13, 0x27, 0x3B;
//    lanes 5..15 of out_data are 0.
//  3 rows=6, ready toggling 1,0,0,1,... -> never more than 2 rows buffered; all 6 rows
//    in order, none lost or duplicated; FIFO-overflow assertion stays silent.
//  4 rows=0 -> no mem_en; done 2 cycles after start. bytes=31 -> mem_control=16.
//  5 rst asserted mid-DRAIN with out_valid=1 -> all outputs 0 immediately; a new start
//    after release runs a clean tile.
//  6 With LOADER_PERF_CNT_EN: ready held 0 for 7 cycles while out_valid=1 -> stall_cycles=7.

Source files
------------

// File: rtl/gemm_pkg.sv
// gemm_pkg: shared types and constants for the GEMM tile loader.
//   LANES / D_WID / ROW_W : row geometry and counter width
//   row_t                 : one scratchpad row, lane 0 = lowest byte address
//   loader_state_e        : loader FSM encoding
//   clamp_bytes()         : limits a requested byte count to one row
package gemm_pkg;

    localparam int unsigned LANES = 16;
    localparam int unsigned D_WID = 8;
    localparam int unsigned ROW_W = 5;

    typedef logic [LANES-1:0][D_WID-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

    function automatic logic [ROW_W-1:0] clamp_bytes(input logic [ROW_W-1:0] b);
        return (b > ROW_W'(LANES)) ? ROW_W'(LANES) : b;
    endfunction

endpackage

// File: rtl/loader_row_fifo.sv
// loader_row_fifo: 2-entry FIFO of {row, last} used by the tile loader.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   push, push_data/last  write one entry
//   pop                   drop the head entry
//   head_data, head_last  current head entry (stale when empty)
//   count, full, empty    occupancy
module loader_row_fifo
    import gemm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  row_t       push_data,
    input  logic       push_last,
    input  logic       pop,
    output row_t       head_data,
    output logic       head_last,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);

    row_t       data_q [2];
    logic       last_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q[0] <= 1'b0;
            last_q[1] <= 1'b0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= push_data;
                last_q[wr_ptr_q] <= push_last;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data = data_q[rd_ptr_q];
    assign head_last = last_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);

    // The loader's credit rule must make these unreachable.
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/gemm_tile_loader.sv
// gemm_tile_loader: read master that walks a tile of rows out of the banked scratchpad
// and streams them on a valid/ready link.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    1-cycle pulse, captures base_addr/row_stride/num_rows/row_bytes
//   busy, done               tile in progress / 1-cycle completion pulse
//   mem_en, mem_rdwr         scratchpad request (read only, rdwr tied 0)
//   mem_control, mem_addr    clamped byte count and row address
//   mem_rd_data              read data, valid 1 cycle after mem_en
//   out_valid/ready/data/last  row output stream
//   stall_cycles             only with LOADER_PERF_CNT_EN: backpressure stall counter
// Build option: define LOADER_PERF_CNT_EN to add the stall_cycles port and counter.
module gemm_tile_loader
    import gemm_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            base_addr,
    input  logic [31:0]            row_stride,
    input  logic [ROW_W-1:0]       num_rows,
    input  logic [ROW_W-1:0]       row_bytes,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_en,
    output logic                   mem_rdwr,
    output logic [ROW_W-1:0]       mem_control,
    output logic [31:0]            mem_addr,
    input  logic [LANES*D_WID-1:0] mem_rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*D_WID-1:0] out_data,
    output logic                   out_last
`ifdef LOADER_PERF_CNT_EN
    ,
    output logic [31:0]            stall_cycles
`endif
);

    loader_state_e    state_q, state_d;
    logic             start_q;        // accepted start, acted on the following cycle
    logic             zero_q;         // captured tile has no rows or no bytes
    logic [31:0]      addr_q;
    logic [31:0]      stride_q;
    logic [ROW_W-1:0] bytes_q;
    logic [ROW_W-1:0] issue_left_q;
    logic             inflight_q;
    logic             inflight_last_q;

    logic             accept_start;
    logic             issue_phase;
    logic             last_issue;
    logic [2:0]       occ;
    logic [2:0]       occ_after_pop;
    logic             pop_any;
    logic             fifo_push;
    logic             fifo_pop;
    row_t             fifo_head;
    logic             fifo_head_last;
    logic [1:0]       fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    assign accept_start = start && (state_q == IDLE) && !start_q;

    // Row 0 is issued in the cycle after start so the first row is out 2 cycles after start.
    assign issue_phase = (state_q == ISSUE) || ((state_q == IDLE) && start_q && !zero_q);
    assign last_issue  = (issue_left_q == ROW_W'(1));

    // Rows owed to the consumer: buffered plus the one returning from memory this cycle.
    assign occ           = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign out_valid     = !fifo_empty || inflight_q;
    assign pop_any       = out_valid && out_ready;
    assign occ_after_pop = occ - {2'b00, pop_any};

    assign mem_en = issue_phase && (issue_left_q != '0) && (occ_after_pop < 3'd2);

    // Returning data bypasses the FIFO when it is empty and the consumer takes it now.
    assign fifo_pop  = pop_any && !fifo_empty;
    assign fifo_push = inflight_q && !(fifo_empty && out_ready);

    loader_row_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (mem_rd_data),
        .push_last (inflight_last_q),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .head_last (fifo_head_last),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        if (!fifo_empty) begin
            out_data = fifo_head;
            out_last = fifo_head_last;
        end else if (inflight_q) begin
            out_data = mem_rd_data;
            out_last = inflight_last_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_q) begin
                    if (zero_q) begin
                        state_d = DONE;
                    end else if (mem_en && last_issue) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (mem_en && last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (occ_after_pop == 3'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            start_q         <= 1'b0;
            zero_q          <= 1'b0;
            addr_q          <= '0;
            stride_q        <= '0;
            bytes_q         <= '0;
            issue_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            start_q         <= accept_start;
            inflight_q      <= mem_en;
            inflight_last_q <= mem_en && last_issue;
            if (accept_start) begin
                zero_q       <= (num_rows == '0) || (row_bytes == '0);
                addr_q       <= base_addr;
                stride_q     <= row_stride;
                bytes_q      <= clamp_bytes(row_bytes);
                issue_left_q <= num_rows;
            end else if (mem_en) begin
                addr_q       <= addr_q + stride_q;
                issue_left_q <= issue_left_q - ROW_W'(1);
            end
        end
    end

    assign busy        = start_q || (state_q == ISSUE) || (state_q == DRAIN);
    assign done        = (state_q == DONE);
    assign mem_rdwr    = 1'b0;
    assign mem_addr    = addr_q;
    assign mem_control = bytes_q;

    a_no_push_pop_full: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && fifo_pop && fifo_full));

`ifdef LOADER_PERF_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (accept_start) begin
            stall_q <= '0;
        end else if (busy && out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
